sd_arbiter: RTL

SD_ARBITER -- requirements
Module: sd_arbiter

---
 rtl/tatung_sd_pkg.sv | 18 +
 rtl/sd_req_latch.sv | 43 ++++
 rtl/sd_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tatung_sd_pkg.sv
// Shared definitions for the two-drive SD arbiter.
//   NUM_DRIVES : number of floppy-emulation drives sharing one SD host port
//   LBA_W      : sector address width
//   sd_state_t : arbiter FSM states
package tatung_sd_pkg;

    localparam int NUM_DRIVES = 2;
    localparam int LBA_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE,
        ST_ERR
    } sd_state_t;

endpackage

// File: rtl/sd_req_latch.sv
// Per-drive request latch: captures one outstanding sector request.
//   clk_sys, reset_n : clock and async active-low reset
//   rd, wr           : request pulses from the drive (rd wins if both high)
//   lba              : sector address presented with the pulse
//   clr              : arbiter has finished (done or aborted) this drive
//   pending          : a request is waiting or in service
//   lba_q, is_rd     : latched address and direction
module sd_req_latch
    import tatung_sd_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             rd,
    input  logic             wr,
    input  logic [LBA_W-1:0] lba,
    input  logic             clr,
    output logic             pending,
    output logic [LBA_W-1:0] lba_q,
    output logic             is_rd
);

    // A completing drive may be re-requested in the same cycle: the clear
    // frees the slot, so the new pulse is taken rather than dropped.
    logic take;
    assign take = (rd | wr) & (~pending | clr);

    // NOTE: non-blocking assignments for every registered signal so all
    // flops update together from values sampled at the same edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            lba_q   <= '0;
            is_rd   <= 1'b0;
        end else if (take) begin
            pending <= 1'b1;
            lba_q   <= lba;
            is_rd   <= rd;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sd_arbiter.sv
// Round-robin arbiter sharing one SD host port between two drives.
//   clk_sys, reset_n : clock and async active-low reset
//   req_lba/rd/wr    : per-drive sector requests
//   req_buff_din     : per-drive buffer data toward the host
//   req_buff_wr      : per-drive buffer write strobe (granted drive, XFER only)
//   req_done/err     : one-cycle completion / timeout-abort pulses
//   sd_lba/rd/wr     : request to the host SPI block
//   sd_ack           : host busy with the sector transfer
//   sd_buff_wr       : host buffer write strobe
//   sd_buff_din      : buffer data of the granted drive
//   grant            : drive currently or last served
//   busy             : arbiter not idle
module sd_arbiter
    import tatung_sd_pkg::*;
#(
    parameter int TIMEOUT = 16000000,
    parameter int TW      = 24
) (
    input  logic                                 clk_sys,
    input  logic                                 reset_n,
    input  logic [NUM_DRIVES-1:0][LBA_W-1:0]     req_lba,
    input  logic [NUM_DRIVES-1:0]                req_rd,
    input  logic [NUM_DRIVES-1:0]                req_wr,
    input  logic [NUM_DRIVES-1:0][7:0]           req_buff_din,
    output logic [NUM_DRIVES-1:0]                req_buff_wr,
    output logic [NUM_DRIVES-1:0]                req_done,
    output logic [NUM_DRIVES-1:0]                req_err,
    output logic [LBA_W-1:0]                     sd_lba,
    output logic [NUM_DRIVES-1:0]                sd_rd,
    output logic [NUM_DRIVES-1:0]                sd_wr,
    input  logic                                 sd_ack,
    input  logic                                 sd_buff_wr,
    output logic [7:0]                           sd_buff_din,
    output logic                                 grant,
    output logic                                 busy
);

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    sd_state_t                        state, state_nxt;
    logic                             last_grant;
    logic [TW-1:0]                    cnt;
    logic                             sel;
    logic [NUM_DRIVES-1:0]            sel_mask;
    logic [NUM_DRIVES-1:0]            pending, lat_rd, clr;
    logic [NUM_DRIVES-1:0][LBA_W-1:0] lat_lba;

    for (genvar d = 0; d < NUM_DRIVES; d++) begin : g_drive
        sd_req_latch u_latch (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .rd      (req_rd[d]),
            .wr      (req_wr[d]),
            .lba     (req_lba[d]),
            .clr     (clr[d]),
            .pending (pending[d]),
            .lba_q   (lat_lba[d]),
            .is_rd   (lat_rd[d])
        );
    end

    // Winner selection: with both pending, favour the drive not served last.
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sel = 1'b0;
        if (pending == '1)
            sel = ~last_grant;
        else if (pending[1])
            sel = 1'b1;
        sel_mask      = '0;
        sel_mask[sel] = 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Completion (ack low) takes priority over the timeout in XFER.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|pending) state_nxt = ST_REQ;
            ST_REQ: begin
                if (sd_ack)               state_nxt = ST_XFER;
                else if (cnt == CNT_LAST) state_nxt = ST_ERR;
            end
            ST_XFER: begin
                if (!sd_ack)              state_nxt = ST_DONE;
                else if (cnt == CNT_LAST) state_nxt = ST_ERR;
            end
            ST_DONE, ST_ERR: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sd_rd      <= '0;
            sd_wr      <= '0;
            sd_lba     <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_REQ) begin
                        grant  <= sel;
                        sd_lba <= lat_lba[sel];
                        sd_rd  <= lat_rd[sel] ? sel_mask : '0;
                        sd_wr  <= lat_rd[sel] ? '0 : sel_mask;
                        cnt    <= '0;
                    end
                end
                ST_REQ, ST_XFER: begin
                    cnt <= cnt + TW'(1);
                    // Leaving REQ (acked or aborted) withdraws the request.
                    if (state_nxt != ST_REQ) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                    end
                end
                ST_DONE, ST_ERR: last_grant <= grant;
                default: ;
            endcase
        end
    end

    // Strobes and pulses are decoded from state so an ack seen outside
    // XFER can never reach a drive buffer.
    always_comb begin
        req_buff_wr = '0;
        req_done    = '0;
        req_err     = '0;
        if (state == ST_XFER) req_buff_wr[grant] = sd_buff_wr;
        if (state == ST_DONE) req_done[grant]    = 1'b1;
        if (state == ST_ERR)  req_err[grant]     = 1'b1;
    end

    assign clr         = req_done | req_err;
    assign sd_buff_din = req_buff_din[grant];
    assign busy        = (state != ST_IDLE);

endmodule
